// File: rtl/plic_claim_arbiter.sv
// PLIC claim/complete arbiter for one hart: collects gateway requests, picks the
// highest-priority pending source, raises irq above threshold, and runs claim/complete.
module plic_claim_arbiter #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = $clog2(NSRC + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NSRC-1:0]          gw_valid,
    output logic [NSRC-1:0]          gw_ready,
    output logic [NSRC-1:0]          gw_complete,
    input  logic [NSRC*PRIO_W-1:0]   prio,
    input  logic [PRIO_W-1:0]        threshold,
    output logic                     irq,
    input  logic                     claim_valid,
    output logic [ID_W-1:0]          claim_id,
    input  logic                     complete_valid,
    input  logic [ID_W-1:0]          complete_id
);

    // Gateway handshake: a request transfers on any cycle where gw_valid[i] and
    // gw_ready[i] are both high; ready holds low while the source is pending or claimed.
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   claimed;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;

    logic [NSRC-1:0]   accepted;
    logic [NSRC-1:0]   claim_mask;
    logic [NSRC-1:0]   complete_mask;
    logic [NSRC-1:0]   pending_next;
    logic [NSRC-1:0]   claimed_next;
    logic [NSRC-1:0]   gw_complete_next;
    logic [ID_W-1:0]   best_id_next;
    logic [PRIO_W-1:0] best_prio_next;
    logic [PRIO_W-1:0] src_prio;
    logic              irq_next;

    assign gw_ready = ~pending & ~claimed;
    assign accepted = gw_valid & gw_ready;
    assign claim_id = irq ? best_id : '0;

    // ID decode: IDs 0 and > NSRC match no bit, so they fall out naturally.
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_mask[i]    = claim_valid && (claim_id == ID_W'(i + 1));
            complete_mask[i] = complete_valid && (complete_id == ID_W'(i + 1)) && claimed[i];
        end
    end

    // A claim on the same source as a complete wins: claimed stays set, no pulse.
    always_comb begin
        pending_next     = (pending | accepted) & ~claim_mask;
        claimed_next     = (claimed & ~complete_mask) | claim_mask;
        gw_complete_next = complete_mask & ~claim_mask;
    end

    // Strict compare from a zero start skips priority-0 sources and keeps the lowest ID on ties.
    always_comb begin
        best_id_next   = '0;
        best_prio_next = '0;
        src_prio       = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_prio = prio[i*PRIO_W +: PRIO_W];
            if (pending_next[i] && (src_prio > best_prio_next)) begin
                best_prio_next = src_prio;
                best_id_next   = ID_W'(i + 1);
            end
        end
        irq_next = (best_prio_next > threshold);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending     <= '0;
            claimed     <= '0;
            best_id     <= '0;
            best_prio   <= '0;
            irq         <= 1'b0;
            gw_complete <= '0;
        end else begin
            pending     <= pending_next;
            claimed     <= claimed_next;
            best_id     <= best_id_next;
            best_prio   <= best_prio_next;
            irq         <= irq_next;
            gw_complete <= gw_complete_next;
        end
    end

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Table-driven bench for plic_claim_arbiter with an expected-value queue,
// plus a hand-written asynchronous reset sequence.
module tb_plic_claim_arbiter;
    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 4;
    localparam int OBS_W  = 1 + ID_W + 2 * NSRC;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NSRC-1:0]        gw_valid;
    logic [NSRC-1:0]        gw_ready;
    logic [NSRC-1:0]        gw_complete;
    logic [NSRC*PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]      threshold;
    logic                   irq;
    logic                   claim_valid;
    logic [ID_W-1:0]        claim_id;
    logic                   complete_valid;
    logic [ID_W-1:0]        complete_id;

    plic_claim_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .gw_valid       (gw_valid),
        .gw_ready       (gw_ready),
        .gw_complete    (gw_complete),
        .prio           (prio),
        .threshold      (threshold),
        .irq            (irq),
        .claim_valid    (claim_valid),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NSRC-1:0]        gv;
        logic                   cv;
        logic                   mv;
        logic [ID_W-1:0]        mid;
        logic [NSRC*PRIO_W-1:0] pr;
        logic [PRIO_W-1:0]      thr;
        logic [OBS_W-1:0]       exp;
    } vec_t;

    vec_t             vecs[$];
    logic [OBS_W-1:0] exp_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;

    function automatic logic [NSRC*PRIO_W-1:0] pv(input int s, input int v);
        logic [NSRC*PRIO_W-1:0] r;
        r = '0;
        r[(s-1)*PRIO_W +: PRIO_W] = PRIO_W'(v);
        return r;
    endfunction

    function automatic logic [OBS_W-1:0] ex(input logic i, input logic [ID_W-1:0] c,
                                            input logic [NSRC-1:0] r, input logic [NSRC-1:0] g);
        return {i, c, r, g};
    endfunction

    function automatic void add(input logic [NSRC-1:0] gv, input logic cv, input logic mv,
                                input logic [ID_W-1:0] mid, input logic [NSRC*PRIO_W-1:0] pr,
                                input logic [PRIO_W-1:0] thr, input logic [OBS_W-1:0] e);
        vec_t v;
        v.gv = gv; v.cv = cv; v.mv = mv; v.mid = mid; v.pr = pr; v.thr = thr; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [NSRC-1:0] gv, input logic cv, input logic mv,
                         input logic [ID_W-1:0] mid, input logic [NSRC*PRIO_W-1:0] pr,
                         input logic [PRIO_W-1:0] thr);
        gw_valid = gv; claim_valid = cv; complete_valid = mv; complete_id = mid;
        prio = pr; threshold = thr;
    endtask

    task automatic check_obs(input string name);
        logic [OBS_W-1:0] got;
        logic [OBS_W-1:0] e;
        got = {irq, claim_id, gw_ready, gw_complete};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got irq/id/ready/gwc=%h", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got irq=%b id=%0d ready=%h gwc=%h, expected irq=%b id=%0d ready=%h gwc=%h",
                         name, got[OBS_W-1], got[2*NSRC +: ID_W], got[NSRC +: NSRC], got[NSRC-1:0],
                         e[OBS_W-1], e[2*NSRC +: ID_W], e[NSRC +: NSRC], e[NSRC-1:0]);
            end
        end
    endtask

    localparam logic [NSRC*PRIO_W-1:0] P0 = '0;

    initial begin
        // Claim returns 3 one cycle after the request; irq drops after the claim.
        add(8'h00, 1'b0, 1'b0, 4'd0, pv(3,5), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h00)); // 0
        add(8'h04, 1'b0, 1'b0, 4'd0, pv(3,5), 3'd2, ex(1'b1, 4'd3, 8'hFB, 8'h00)); // 1
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(3,5), 3'd2, ex(1'b0, 4'd0, 8'hFB, 8'h00)); // 2
        add(8'h00, 1'b0, 1'b1, 4'd3, pv(3,5), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h04)); // 3
        add(8'h00, 1'b0, 1'b0, 4'd0, pv(3,5), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h00)); // 4
        // Priority equal to threshold never interrupts; lowering threshold does.
        add(8'h01, 1'b0, 1'b0, 4'd0, pv(1,3), 3'd3, ex(1'b0, 4'd0, 8'hFE, 8'h00)); // 5
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(1,3), 3'd3, ex(1'b0, 4'd0, 8'hFE, 8'h00)); // 6
        add(8'h00, 1'b0, 1'b0, 4'd0, pv(1,3), 3'd2, ex(1'b1, 4'd1, 8'hFE, 8'h00)); // 7
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(1,3), 3'd2, ex(1'b0, 4'd0, 8'hFE, 8'h00)); // 8
        add(8'h00, 1'b0, 1'b1, 4'd1, pv(1,3), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h01)); // 9
        // Equal priorities: lowest ID first, then the other, then nothing.
        add(8'h12, 1'b0, 1'b0, 4'd0, pv(2,4)|pv(5,4), 3'd2, ex(1'b1, 4'd2, 8'hED, 8'h00)); // 10
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(2,4)|pv(5,4), 3'd2, ex(1'b1, 4'd5, 8'hED, 8'h00)); // 11
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(2,4)|pv(5,4), 3'd2, ex(1'b0, 4'd0, 8'hED, 8'h00)); // 12
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(2,4)|pv(5,4), 3'd2, ex(1'b0, 4'd0, 8'hED, 8'h00)); // 13
        add(8'h00, 1'b0, 1'b1, 4'd2, pv(2,4)|pv(5,4), 3'd2, ex(1'b0, 4'd0, 8'hEF, 8'h02)); // 14
        add(8'h00, 1'b0, 1'b1, 4'd5, pv(2,4)|pv(5,4), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h10)); // 15
        // Ignored completes: ID 0, out-of-range ID, unclaimed ID.
        add(8'h00, 1'b0, 1'b1, 4'd0, P0, 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h00)); // 16
        add(8'h00, 1'b0, 1'b1, 4'd9, P0, 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h00)); // 17
        add(8'h00, 1'b0, 1'b1, 4'd4, P0, 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h00)); // 18
        // Source 7: claim, complete pulses once, repeated complete is ignored.
        add(8'h40, 1'b0, 1'b0, 4'd0, pv(7,6), 3'd2, ex(1'b1, 4'd7, 8'hBF, 8'h00)); // 19
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(7,6), 3'd2, ex(1'b0, 4'd0, 8'hBF, 8'h00)); // 20
        add(8'h00, 1'b0, 1'b1, 4'd7, pv(7,6), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h40)); // 21
        add(8'h00, 1'b0, 1'b1, 4'd7, pv(7,6), 3'd2, ex(1'b0, 4'd0, 8'hFF, 8'h00)); // 22
        // Priority-0 source stays pending unselected until its priority rises.
        add(8'h01, 1'b0, 1'b0, 4'd0, P0, 3'd0, ex(1'b0, 4'd0, 8'hFE, 8'h00)); // 23
        add(8'h00, 1'b1, 1'b0, 4'd0, P0, 3'd0, ex(1'b0, 4'd0, 8'hFE, 8'h00)); // 24
        add(8'h00, 1'b0, 1'b0, 4'd0, pv(1,1), 3'd0, ex(1'b1, 4'd1, 8'hFE, 8'h00)); // 25
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(1,1), 3'd0, ex(1'b0, 4'd0, 8'hFE, 8'h00)); // 26
        // Claim of 8 and complete of 1 in the same cycle both take effect.
        add(8'h80, 1'b0, 1'b0, 4'd0, pv(1,1)|pv(8,2), 3'd0, ex(1'b1, 4'd8, 8'h7E, 8'h00)); // 27
        add(8'h00, 1'b1, 1'b1, 4'd1, pv(1,1)|pv(8,2), 3'd0, ex(1'b0, 4'd0, 8'h7F, 8'h01)); // 28
        add(8'h00, 1'b0, 1'b1, 4'd8, pv(1,1)|pv(8,2), 3'd0, ex(1'b0, 4'd0, 8'hFF, 8'h80)); // 29
        // Higher priority at a higher ID beats a lower ID.
        add(8'h22, 1'b0, 1'b0, 4'd0, pv(2,3)|pv(6,7), 3'd0, ex(1'b1, 4'd6, 8'hDD, 8'h00)); // 30
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(2,3)|pv(6,7), 3'd0, ex(1'b1, 4'd2, 8'hDD, 8'h00)); // 31
        add(8'h00, 1'b1, 1'b0, 4'd0, pv(2,3)|pv(6,7), 3'd0, ex(1'b0, 4'd0, 8'hDD, 8'h00)); // 32
        add(8'h00, 1'b0, 1'b1, 4'd6, pv(2,3)|pv(6,7), 3'd0, ex(1'b0, 4'd0, 8'hFD, 8'h20)); // 33
        add(8'h00, 1'b0, 1'b1, 4'd2, pv(2,3)|pv(6,7), 3'd0, ex(1'b0, 4'd0, 8'hFF, 8'h02)); // 34

        // Clock/reset
        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 4'd0, P0, 3'd0);
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(ex(1'b0, 4'd0, 8'hFF, 8'h00));
        check_obs("reset_state");
        reset = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].gv, vecs[k].cv, vecs[k].mv, vecs[k].mid, vecs[k].pr, vecs[k].thr);
            exp_q.push_back(vecs[k].exp);
            @(posedge clock);
            #1;
            check_obs($sformatf("vec%0d", k));
        end

        // Async reset with two pending, one claimed and a complete in flight.
        drive(8'h0E, 1'b0, 1'b0, 4'd0, pv(2,4)|pv(3,4)|pv(4,4), 3'd0);
        exp_q.push_back(ex(1'b1, 4'd2, 8'hF1, 8'h00));
        @(posedge clock); #1;
        check_obs("rst_setup_pend");
        drive(8'h00, 1'b1, 1'b0, 4'd0, pv(2,4)|pv(3,4)|pv(4,4), 3'd0);
        exp_q.push_back(ex(1'b1, 4'd3, 8'hF1, 8'h00));
        @(posedge clock); #1;
        check_obs("rst_setup_claim");
        drive(8'h00, 1'b0, 1'b1, 4'd2, pv(2,4)|pv(3,4)|pv(4,4), 3'd0);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(ex(1'b0, 4'd0, 8'hFF, 8'h00));
        check_obs("rst_async_clear");
        @(posedge clock); #1;
        drive(8'h00, 1'b0, 1'b0, 4'd0, pv(2,4)|pv(3,4)|pv(4,4), 3'd0);
        reset = 1'b1;
        exp_q.push_back(ex(1'b0, 4'd0, 8'hFF, 8'h00));
        check_obs("rst_held");
        @(posedge clock); #1;
        exp_q.push_back(ex(1'b0, 4'd0, 8'hFF, 8'h00));
        check_obs("rst_no_pulse");

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_claim_arbiter.md
PLIC_CLAIM_ARBITER -- requirements
Module: plic_claim_arbiter

Interface
REQ-001 Parameter NSRC, 8: number of interrupt sources; source IDs are 1..NSRC, and ID 0 means "none".
REQ-002 Parameter PRIO_W, 3: width of each priority field; priority 0 means "never interrupt".
REQ-003 Parameter ID_W, clog2(NSRC+1): width of every source-ID port.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; all state cleared while low.
REQ-006 gw_valid  in  NSRC  bit i-1 is the gateway request for source i.
REQ-007 gw_ready  out  NSRC  bit i-1 accepts the source-i request.
REQ-008 gw_complete  out  NSRC  bit i-1 is a one-cycle completion pulse to the source-i gateway.
REQ-009 prio  in  NSRC*PRIO_W  priority of source i in bits [i*PRIO_W-1 : (i-1)*PRIO_W].
REQ-010 threshold  in  PRIO_W  hart threshold.
REQ-011 irq  out  1  registered interrupt request to the hart.
REQ-012 claim_valid  in  1  one-cycle claim strobe.
REQ-013 claim_id  out  ID_W  ID returned for a claim (combinational from registered state).
REQ-014 complete_valid  in  1  one-cycle completion strobe.
REQ-015 complete_id  in  ID_W  ID being completed.

Function
REQ-016 State SHALL consist of pending[NSRC], claimed[NSRC], best_id[ID_W], best_prio[PRIO_W], irq and gw_complete registers.
REQ-017 gw_ready[i] SHALL equal ~pending[i] & ~claimed[i], combinationally.
REQ-018 A handshake (gw_valid[i] & gw_ready[i]) SHALL set pending[i] at the next edge.
REQ-019 pending_next SHALL be (pending | accepted handshakes) with the claimed bit cleared when a claim returns a nonzero ID.
REQ-020 best_id/best_prio SHALL register, every cycle, the pending_next source with the highest nonzero priority.
- Ties go to the lowest ID.
- If no pending_next source has nonzero priority, best_id = 0 and best_prio = 0.
REQ-021 irq SHALL register (best_prio_next > threshold), unsigned compare; latency from handshake to irq is exactly 1 cycle.
REQ-022 claim_id SHALL equal best_id when irq = 1, and 0 otherwise.
REQ-023 When claim_valid = 1 and claim_id != 0:
- pending[claim_id] SHALL clear and claimed[claim_id] SHALL set at the same edge.
- The arbitration result SHALL exclude that source in the same edge, so back-to-back claims never return the same ID.
REQ-024 A claim returning 0 SHALL change no state.
REQ-025 When complete_valid = 1, complete_id is in 1..NSRC and claimed[complete_id] = 1:
- claimed[complete_id] SHALL clear.
- gw_complete[complete_id-1] SHALL be high for exactly the following cycle.
REQ-026 A complete with ID 0, an ID > NSRC, or an unclaimed ID SHALL be ignored (no pulse, no state change).
REQ-027 Claim and complete in the same cycle SHALL both take effect; if they name the same source, the claim wins and claimed stays set.
REQ-028 Priority or threshold changes SHALL affect best_*/irq at the next edge only.
REQ-029 A pending source with priority 0 SHALL stay pending but never be selected.

Reset
REQ-030 While reset is low, pending, claimed, best_id, best_prio, irq and gw_complete SHALL be 0 immediately (asynchronously), so gw_ready is all-ones.
REQ-031 Reset deassertion SHALL be synchronized by the integrator; the block first samples inputs at the first edge with reset high.
REQ-032 Reset mid-claim or mid-complete SHALL discard the operation with no gw_complete pulse.

Verification
REQ-033 NSRC=8, prio[3]=5, threshold=2, gw_valid[2] pulsed at cycle N -> pending[2] set and irq=1 at N+1; claim at N+2 returns claim_id=3, and irq=0 at N+3.
REQ-034 Sources 2 and 5 pending, both priority 4 -> claim_id=2; the next-cycle claim returns 5; a third claim returns 0 with no state change.
REQ-035 Source 7 claimed; complete_valid with complete_id=7 at cycle M -> gw_complete[6]=1 only in cycle M+1 and gw_ready[6]=1 from M+1; repeating the complete yields no pulse.
REQ-036 Source 1 priority 3 with threshold 3 -> irq stays 0 and claim returns 0; lowering threshold to 2 -> irq=1 one cycle later.
REQ-037 complete_id = 0 or 9, or a complete of an unclaimed ID -> no gw_complete pulse and state unchanged.
REQ-038 Reset driven low with two sources pending and one claimed -> all outputs 0 and gw_ready = 8'hFF before the next clock edge.
